dual_beam_trig_scaler: RTL and testbench

DUAL_BEAM_TRIG_SCALER -- requirements
Module: dual_beam_trig_scaler

---
 rtl/dual_beam_trig_scaler_pkg.sv | 22 ++
 rtl/dual_beam_trig_scaler_if.sv | 25 ++
 rtl/dual_beam_trig_scaler_holdoff.sv | 55 +++++
 rtl/dual_beam_trig_scaler.sv | 106 ++++++++++
 tb/tb_dual_beam_trig_scaler.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dual_beam_trig_scaler_pkg.sv
// Shared beam-trigger definitions: beam indices, threshold width, the threshold
// sequencer state type, and the magnitude-to-two's-complement helper.
package dual_beam_trig_scaler_pkg;

  localparam int BEAM_A   = 0;
  localparam int BEAM_B   = 1;
  localparam int NBEAMS   = 2;
  localparam int THRESH_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } thr_state_t;

  // The beam stage compares against a negative level, so the host magnitude is negated mod 2^18.
  function automatic logic [THRESH_W-1:0] thresh_neg(input logic [THRESH_W-1:0] mag);
    return (~mag) + THRESH_W'(1);
  endfunction

endpackage

// File: rtl/dual_beam_trig_scaler_if.sv
// Host threshold write port and the threshold load/commit bus toward the beam stage.
interface dual_beam_trig_scaler_if;
  import dual_beam_trig_scaler_pkg::*;

  // Write is a single-cycle strobe with no ready: it is taken only while busy_o=0
  // and silently dropped otherwise, so the host must watch busy_o before writing.
  logic                thresh_wr_i;
  logic [NBEAMS-1:0]   thresh_sel_i;
  logic [THRESH_W-1:0] thresh_dat_i;
  logic [THRESH_W-1:0] thresh_o;
  logic [NBEAMS-1:0]   thresh_ce_o;
  logic                update_o;
  logic                busy_o;

  modport master (
    output thresh_wr_i, thresh_sel_i, thresh_dat_i,
    input  thresh_o, thresh_ce_o, update_o, busy_o
  );

  modport slave (
    input  thresh_wr_i, thresh_sel_i, thresh_dat_i,
    output thresh_o, thresh_ce_o, update_o, busy_o
  );

endinterface

// File: rtl/dual_beam_trig_scaler_holdoff.sv
// One beam: trigger holdoff with a registered one-cycle output pulse, plus a
// saturating per-gate trigger counter latched on the period tick.
module trig_holdoff_scaler #(
  parameter int HOLDOFF   = 4,
  parameter int SCAL_BITS = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 trig_i,
  input  logic                 tick_i,
  output logic                 trig_o,
  output logic [SCAL_BITS-1:0] scaler_o
);

  localparam int                   HW       = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HW-1:0]        HOLD_LD  = HW'(HOLDOFF);
  localparam logic [SCAL_BITS-1:0] SCAL_MAX = '1;

  logic [HW-1:0]        r_hold;
  logic [SCAL_BITS-1:0] r_cnt;
  logic                 r_trig;
  logic [SCAL_BITS-1:0] r_scal;
  logic                 w_acc;
  logic [SCAL_BITS-1:0] w_cnt_inc;

  assign w_acc     = trig_i && (r_hold == '0);
  // The count including this cycle's acceptance, so a tick-cycle trigger lands in the latched value.
  assign w_cnt_inc = (w_acc && (r_cnt != SCAL_MAX)) ? r_cnt + SCAL_BITS'(1) : r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold <= '0;
      r_cnt  <= '0;
      r_trig <= 1'b0;
      r_scal <= '0;
    end else begin
      r_trig <= w_acc;
      if (w_acc) begin
        r_hold <= HOLD_LD;
      end else if (r_hold != '0) begin
        r_hold <= r_hold - HW'(1);
      end
      if (tick_i) begin
        r_scal <= w_cnt_inc;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= w_cnt_inc;
      end
    end
  end

  assign trig_o   = r_trig;
  assign scaler_o = r_scal;

endmodule

// File: rtl/dual_beam_trig_scaler.sv
// Dual-beam trigger holdoff and gated scalers, with a threshold sequencer that
// commits new thresholds to the beam stage only on gate boundaries.
module dual_beam_trig_scaler
  import dual_beam_trig_scaler_pkg::*;
#(
  parameter int HOLDOFF     = 4,
  parameter int SCAL_BITS   = 16,
  parameter int PERIOD_BITS = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NBEAMS-1:0]      trig_i,
  input  logic [PERIOD_BITS-1:0] period_i,
  output logic [NBEAMS-1:0]      trig_o,
  output logic [SCAL_BITS-1:0]   scalerA_o,
  output logic [SCAL_BITS-1:0]   scalerB_o,
  output logic                   scaler_valid_o,
  dual_beam_trig_scaler_if.slave tif,
  output thr_state_t             dbg_state_o
);

  logic [PERIOD_BITS-1:0] r_pcnt;
  logic [PERIOD_BITS-1:0] w_plast;
  logic                   w_tick;
  logic                   r_valid;
  logic [SCAL_BITS-1:0]   w_scal [NBEAMS];
  thr_state_t             r_state;
  thr_state_t             w_state_nxt;
  logic [NBEAMS-1:0]      r_mask;
  logic [THRESH_W-1:0]    r_thresh;

  // A zero period behaves as one, giving a tick every cycle.
  assign w_plast = (period_i == '0) ? '0 : period_i - PERIOD_BITS'(1);
  assign w_tick  = (r_pcnt >= w_plast);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pcnt  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_pcnt  <= w_tick ? '0 : r_pcnt + PERIOD_BITS'(1);
      r_valid <= w_tick;
    end
  end

  for (genvar gb = 0; gb < NBEAMS; gb++) begin : g_beam
    trig_holdoff_scaler #(
      .HOLDOFF   (HOLDOFF),
      .SCAL_BITS (SCAL_BITS)
    ) u_beam (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .trig_i   (trig_i[gb]),
      .tick_i   (w_tick),
      .trig_o   (trig_o[gb]),
      .scaler_o (w_scal[gb])
    );
  end

  assign scalerA_o      = w_scal[BEAM_A];
  assign scalerB_o      = w_scal[BEAM_B];
  assign scaler_valid_o = r_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_mask   <= '0;
      r_thresh <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && tif.thresh_wr_i) begin
        r_mask   <= tif.thresh_sel_i;
        r_thresh <= thresh_neg(tif.thresh_dat_i);
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    tif.thresh_o    = r_thresh;
    tif.thresh_ce_o = '0;
    tif.update_o    = 1'b0;
    tif.busy_o      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        tif.busy_o = 1'b0;
        if (tif.thresh_wr_i) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        tif.thresh_ce_o = r_mask;
        w_state_nxt     = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_tick) w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        tif.update_o = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_dual_beam_trig_scaler.sv
// Bench for dual_beam_trig_scaler: three parameterisations driven in lockstep,
// each checked every cycle against a cycle-count based reference model.
module tb_dual_beam_trig_scaler;
  import dual_beam_trig_scaler_pkg::*;

  localparam int NI = 3;

  function automatic int ho_of(input int k);
    case (k)
      0:       return 4;
      1:       return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int sb_of(input int k);
    return (k == 2) ? 4 : 16;
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  trig   = '0;
  logic [23:0] period = 24'd20;
  logic        wr     = 1'b0;
  logic [1:0]  sel    = '0;
  logic [17:0] dat    = '0;

  dual_beam_trig_scaler_if if0 ();
  dual_beam_trig_scaler_if if1 ();
  dual_beam_trig_scaler_if if2 ();

  assign if0.thresh_wr_i = wr;  assign if0.thresh_sel_i = sel;  assign if0.thresh_dat_i = dat;
  assign if1.thresh_wr_i = wr;  assign if1.thresh_sel_i = sel;  assign if1.thresh_dat_i = dat;
  assign if2.thresh_wr_i = wr;  assign if2.thresh_sel_i = sel;  assign if2.thresh_dat_i = dat;

  logic [1:0]  trig_o0, trig_o1, trig_o2;
  logic [15:0] sa0, sb0, sa1, sb1;
  logic [3:0]  sa2, sb2;
  logic        v0, v1, v2;
  thr_state_t  st0, st1, st2;

  dual_beam_trig_scaler #(.HOLDOFF(4), .SCAL_BITS(16), .PERIOD_BITS(24)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .period_i(period), .trig_o(trig_o0),
    .scalerA_o(sa0), .scalerB_o(sb0), .scaler_valid_o(v0), .tif(if0), .dbg_state_o(st0));
  dual_beam_trig_scaler #(.HOLDOFF(0), .SCAL_BITS(16), .PERIOD_BITS(24)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .period_i(period), .trig_o(trig_o1),
    .scalerA_o(sa1), .scalerB_o(sb1), .scaler_valid_o(v1), .tif(if1), .dbg_state_o(st1));
  dual_beam_trig_scaler #(.HOLDOFF(1), .SCAL_BITS(4), .PERIOD_BITS(24)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .period_i(period), .trig_o(trig_o2),
    .scalerA_o(sa2), .scalerB_o(sb2), .scaler_valid_o(v2), .tif(if2), .dbg_state_o(st2));

  logic [1:0]  obs_trig [NI];
  logic [15:0] obs_sa   [NI];
  logic [15:0] obs_sb   [NI];
  logic        obs_v    [NI];
  logic [17:0] obs_thr  [NI];
  logic [1:0]  obs_ce   [NI];
  logic        obs_upd  [NI];
  logic        obs_busy [NI];
  logic        obs_idle [NI];

  assign obs_trig[0] = trig_o0;  assign obs_trig[1] = trig_o1;  assign obs_trig[2] = trig_o2;
  assign obs_sa[0] = sa0;  assign obs_sa[1] = sa1;  assign obs_sa[2] = {12'd0, sa2};
  assign obs_sb[0] = sb0;  assign obs_sb[1] = sb1;  assign obs_sb[2] = {12'd0, sb2};
  assign obs_v[0] = v0;  assign obs_v[1] = v1;  assign obs_v[2] = v2;
  assign obs_thr[0] = if0.thresh_o;  assign obs_thr[1] = if1.thresh_o;  assign obs_thr[2] = if2.thresh_o;
  assign obs_ce[0] = if0.thresh_ce_o;  assign obs_ce[1] = if1.thresh_ce_o;  assign obs_ce[2] = if2.thresh_ce_o;
  assign obs_upd[0] = if0.update_o;  assign obs_upd[1] = if1.update_o;  assign obs_upd[2] = if2.update_o;
  assign obs_busy[0] = if0.busy_o;  assign obs_busy[1] = if1.busy_o;  assign obs_busy[2] = if2.busy_o;
  assign obs_idle[0] = (st0 == ST_IDLE);  assign obs_idle[1] = (st1 == ST_IDLE);  assign obs_idle[2] = (st2 == ST_IDLE);

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // n counts rising edges since reset release; everything derives from it.
  int         n;
  int         m_last [NI][2];
  int         m_cnt  [NI][2];
  logic [1:0] e_trig [NI];
  int         e_scal [NI][2];
  logic       e_valid[NI];
  bit         m_pend;
  int         m_w, m_t, m_thr;
  logic [1:0] m_mask;
  int         e_thr;
  logic [1:0] e_ce;
  logic       e_upd, e_busy;

  function automatic int peff();
    return (period == 24'd0) ? 1 : int'(period);
  endfunction

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < NI; k++) begin
      for (int b = 0; b < 2; b++) begin
        m_last[k][b] = -1000;
        m_cnt[k][b]  = 0;
        e_scal[k][b] = 0;
      end
      e_trig[k]  = 2'b00;
      e_valid[k] = 1'b0;
    end
    m_pend = 1'b0;  m_w = 0;  m_t = 0;  m_thr = 0;  m_mask = 2'b00;
    e_thr = 0;  e_ce = 2'b00;  e_upd = 1'b0;  e_busy = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] t, input logic w, input logic [1:0] s, input logic [17:0] d);
    int p;
    bit tick;
    int cap;
    p    = peff();
    tick = ((n % p) == (p - 1));
    for (int k = 0; k < NI; k++) begin
      cap = (1 << sb_of(k)) - 1;
      for (int b = 0; b < 2; b++) begin
        e_trig[k][b] = t[b] && ((n - m_last[k][b]) > ho_of(k));
        if (e_trig[k][b]) begin
          m_last[k][b] = n;
          m_cnt[k][b]++;
        end
        if (tick) begin
          e_scal[k][b] = (m_cnt[k][b] > cap) ? cap : m_cnt[k][b];
          m_cnt[k][b]  = 0;
        end
      end
      e_valid[k] = tick;
    end
    // A write is taken once the previous sequence has fully returned to idle.
    if (w && (!m_pend || (n > m_t + 1))) begin
      m_pend = 1'b1;
      m_w    = n;
      m_t    = (n + 2) + ((p - 1) - ((n + 2) % p));
      m_thr  = (262144 - int'(d)) % 262144;
      m_mask = s;
    end
    e_thr  = m_thr;
    e_ce   = (m_pend && (n == m_w)) ? m_mask : 2'b00;
    e_upd  = m_pend && (n == m_t);
    e_busy = m_pend && (n >= m_w) && (n <= m_t);
    n++;
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("trig_o[%0d]", k),   obs_trig[k], e_trig[k]);
      chk($sformatf("scalerA[%0d]", k),  obs_sa[k],   e_scal[k][0]);
      chk($sformatf("scalerB[%0d]", k),  obs_sb[k],   e_scal[k][1]);
      chk($sformatf("valid[%0d]", k),    obs_v[k],    e_valid[k]);
      chk($sformatf("thresh_o[%0d]", k), obs_thr[k],  e_thr);
      chk($sformatf("thresh_ce[%0d]", k), obs_ce[k],  e_ce);
      chk($sformatf("update[%0d]", k),   obs_upd[k],  e_upd);
      chk($sformatf("busy[%0d]", k),     obs_busy[k], e_busy);
      chk($sformatf("idle_state[%0d]", k), obs_idle[k], !e_busy);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic reset_cycles(input int cyc);
    rst  = 1'b1;
    trig = 2'b00;
    wr   = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      model_reset();
      compare_all();
    end
    rst = 1'b0;
  endtask

  task automatic cycle(input logic [1:0] t, input logic w, input logic [1:0] s, input logic [17:0] d);
    trig = t;
    wr   = w;
    sel  = s;
    dat  = d;
    model_edge(t, w, s, d);
    @(negedge clk);
    compare_all();
  endtask

  // ---------------- stimulus ----------------
  logic [11:0] seen;
  int          cnt;
  logic [1:0]  rt;
  logic        rw;
  logic [17:0] rd;

  initial begin
    // Holdoff spacing on beam A, then a threshold write with an ignored second write.
    period = 24'd20;
    reset_cycles(2);
    for (int i = 0; i < 12; i++) begin
      cycle(2'b01, 1'b0, 2'b00, 18'd0);
      seen[i] = obs_trig[0][0];
    end
    chk("holdoff_pulses", {20'd0, seen}, 32'h421);
    cycle(2'b00, 1'b1, 2'b01, 18'h00064);
    chk("load_thresh", {14'd0, obs_thr[0]}, 32'h3FF9C);
    chk("load_ce", {30'd0, obs_ce[0]}, 32'h1);
    cycle(2'b00, 1'b0, 2'b00, 18'd0);
    chk("wait_ce", {30'd0, obs_ce[0]}, 32'h0);
    cycle(2'b00, 1'b1, 2'b10, 18'h00005);
    chk("ignored_write", {14'd0, obs_thr[0]}, 32'h3FF9C);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(2'($urandom_range(0, 3)), 1'b0, 2'b00, 18'd0);
      if (obs_upd[0]) cnt++;
    end
    chk("update_pulses", cnt, 1);

    // Every-cycle triggers on beam B over 100-cycle gates.
    period = 24'd100;
    reset_cycles(1);
    cnt = 0;
    for (int i = 0; i < 250; i++) begin
      cycle(2'b10, 1'b0, 2'b00, 18'd0);
      if (obs_v[1]) begin
        cnt++;
        chk("scalerB_ho0", {16'd0, obs_sb[1]}, 32'd100);
        chk("scalerB_sat4", {16'd0, obs_sb[2]}, 32'd15);
      end
    end
    chk("valid_pulses", cnt, 2);

    // Reset while the sequencer waits for a gate boundary.
    period = 24'd50;
    reset_cycles(1);
    for (int i = 0; i < 5; i++) cycle(2'b00, 1'b0, 2'b00, 18'd0);
    cycle(2'b00, 1'b1, 2'b11, 18'h01234);
    for (int i = 0; i < 3; i++) cycle(2'b00, 1'b0, 2'b00, 18'd0);
    chk("in_wait_busy", {31'd0, obs_busy[0]}, 32'd1);
    reset_cycles(1);
    chk("rst_busy", {31'd0, obs_busy[0]}, 32'd0);
    chk("rst_thresh", {14'd0, obs_thr[0]}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      cycle(2'($urandom_range(0, 3)), 1'b0, 2'b00, 18'd0);
      if (obs_upd[0]) cnt++;
    end
    chk("rst_no_update", cnt, 0);

    // Randomised segments, including zero and unit periods and stray resets.
    for (int seg = 0; seg < 6; seg++) begin
      period = (seg == 0) ? 24'd0 : (seg == 1) ? 24'd1 : 24'($urandom_range(2, 16));
      reset_cycles(1 + $urandom_range(0, 1));
      for (int i = 0; i < 400; i++) begin
        if (seg[0]) rt = 2'($urandom_range(0, 3));
        else        rt = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0)};
        rw = ($urandom_range(0, 5) == 0);
        rd = ($urandom_range(0, 7) == 0) ? 18'd0 : 18'($urandom_range(0, 262143));
        cycle(rt, rw, 2'($urandom_range(0, 3)), rd);
        if ($urandom_range(0, 199) == 0) reset_cycles(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
